// File: rtl/decode_writeback_pipe.sv
// Y86-64 decode/write-back stage: register file, forwarding, load/use detect, D->E register.
// Optional debug read port enabled by defining DW_DEBUG_READ_EN.
module decode_writeback_pipe #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned RID_W   = 4,
   parameter int unsigned RESP_ID = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [2:0]        D_stat,
   input  logic [3:0]        D_icode,
   input  logic [3:0]        D_ifun,
   input  logic [RID_W-1:0]  D_rA,
   input  logic [RID_W-1:0]  D_rB,
   input  logic [DATA_W-1:0] D_valC,
   input  logic [DATA_W-1:0] D_valP,
   input  logic [RID_W-1:0]  e_dstE,
   input  logic [DATA_W-1:0] e_valE,
   input  logic [RID_W-1:0]  M_dstE,
   input  logic [DATA_W-1:0] M_valE,
   input  logic [RID_W-1:0]  M_dstM,
   input  logic [DATA_W-1:0] m_valM,
   input  logic [RID_W-1:0]  W_dstE,
   input  logic [DATA_W-1:0] W_valE,
   input  logic [RID_W-1:0]  W_dstM,
   input  logic [DATA_W-1:0] W_valM,
   input  logic              E_bubble,
`ifdef DW_DEBUG_READ_EN
   input  logic [RID_W-1:0]  dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
`endif
   output logic              d_stall,
   output logic [2:0]        E_stat,
   output logic [3:0]        E_icode,
   output logic [3:0]        E_ifun,
   output logic [DATA_W-1:0] E_valC,
   output logic [DATA_W-1:0] E_valA,
   output logic [DATA_W-1:0] E_valB,
   output logic [RID_W-1:0]  E_dstE,
   output logic [RID_W-1:0]  E_dstM,
   output logic [RID_W-1:0]  E_srcA,
   output logic [RID_W-1:0]  E_srcB
);

   localparam int unsigned      NREG  = 2 ** RID_W;
   localparam logic [RID_W-1:0] RNONE = '1;
   localparam logic [RID_W-1:0] RSP   = RID_W'(RESP_ID);

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // The RNONE slot is never written, so it always holds 0.
   logic [DATA_W-1:0] rf_q [NREG];

   logic [2:0]        ex_stat_q,  ex_stat_d;
   logic [3:0]        ex_icode_q, ex_icode_d;
   logic [3:0]        ex_ifun_q,  ex_ifun_d;
   logic [DATA_W-1:0] ex_valc_q,  ex_valc_d;
   logic [DATA_W-1:0] ex_vala_q,  ex_vala_d;
   logic [DATA_W-1:0] ex_valb_q,  ex_valb_d;
   logic [RID_W-1:0]  ex_dste_q,  ex_dste_d;
   logic [RID_W-1:0]  ex_dstm_q,  ex_dstm_d;
   logic [RID_W-1:0]  ex_srca_q,  ex_srca_d;
   logic [RID_W-1:0]  ex_srcb_q,  ex_srcb_d;

   logic [RID_W-1:0]  src_a, src_b, dst_e, dst_m;

   function automatic logic [DATA_W-1:0] fwd(input logic [RID_W-1:0] src);
      if (src == RNONE)  return '0;
      if (src == e_dstE) return e_valE;
      if (src == M_dstM) return m_valM;
      if (src == M_dstE) return M_valE;
      if (src == W_dstM) return W_valM;
      if (src == W_dstE) return W_valE;
      return rf_q[src];
   endfunction

   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      case (D_icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = D_rA;
         I_POPQ, I_RET:                      src_a = RSP;
         default: ;
      endcase
      case (D_icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:          src_b = D_rB;
         I_PUSHQ, I_POPQ, I_CALL, I_RET:     src_b = RSP;
         default: ;
      endcase
      case (D_icode)
         I_RRMOVQ, I_IRMOVQ, I_OPQ:          dst_e = D_rB;
         I_PUSHQ, I_POPQ, I_CALL, I_RET:     dst_e = RSP;
         default: ;
      endcase
      if (D_icode == I_MRMOVQ || D_icode == I_POPQ) dst_m = D_rA;
   end

   assign d_stall = (ex_icode_q == I_MRMOVQ || ex_icode_q == I_POPQ) &&
                    (ex_dstm_q != RNONE) &&
                    (ex_dstm_q == src_a || ex_dstm_q == src_b);

   always_comb begin
      if (E_bubble || d_stall) begin
         ex_stat_d  = 3'd1;
         ex_icode_d = I_NOP;
         ex_ifun_d  = '0;
         ex_valc_d  = '0;
         ex_vala_d  = '0;
         ex_valb_d  = '0;
         ex_dste_d  = RNONE;
         ex_dstm_d  = RNONE;
         ex_srca_d  = RNONE;
         ex_srcb_d  = RNONE;
      end else begin
         ex_stat_d  = D_stat;
         ex_icode_d = D_icode;
         ex_ifun_d  = D_ifun;
         ex_valc_d  = D_valC;
         ex_vala_d  = (D_icode == I_CALL || D_icode == I_JXX) ? D_valP : fwd(src_a);
         ex_valb_d  = fwd(src_b);
         ex_dste_d  = dst_e;
         ex_dstm_d  = dst_m;
         ex_srca_d  = src_a;
         ex_srcb_d  = src_b;
      end
   end

   // valM is written after valE so it wins when both target the same register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         if (W_dstE != RNONE) rf_q[W_dstE] <= W_valE;
         if (W_dstM != RNONE) rf_q[W_dstM] <= W_valM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_stat_q  <= 3'd1;
         ex_icode_q <= I_NOP;
         ex_ifun_q  <= '0;
         ex_valc_q  <= '0;
         ex_vala_q  <= '0;
         ex_valb_q  <= '0;
         ex_dste_q  <= RNONE;
         ex_dstm_q  <= RNONE;
         ex_srca_q  <= RNONE;
         ex_srcb_q  <= RNONE;
      end else begin
         ex_stat_q  <= ex_stat_d;
         ex_icode_q <= ex_icode_d;
         ex_ifun_q  <= ex_ifun_d;
         ex_valc_q  <= ex_valc_d;
         ex_vala_q  <= ex_vala_d;
         ex_valb_q  <= ex_valb_d;
         ex_dste_q  <= ex_dste_d;
         ex_dstm_q  <= ex_dstm_d;
         ex_srca_q  <= ex_srca_d;
         ex_srcb_q  <= ex_srcb_d;
      end
   end

   assign E_stat  = ex_stat_q;
   assign E_icode = ex_icode_q;
   assign E_ifun  = ex_ifun_q;
   assign E_valC  = ex_valc_q;
   assign E_valA  = ex_vala_q;
   assign E_valB  = ex_valb_q;
   assign E_dstE  = ex_dste_q;
   assign E_dstM  = ex_dstm_q;
   assign E_srcA  = ex_srca_q;
   assign E_srcB  = ex_srcb_q;

`ifdef DW_DEBUG_READ_EN
   assign dbg_data = (!rst_n || dbg_addr == RNONE) ? '0 : rf_q[dbg_addr];
`endif

endmodule
